// File: rtl/compress_handler.sv
// compress_handler: run-length encodes a byte region of RAM, bit by bit.
// Bytes are read in ascending address order, MSB first within each byte.
// Each emitted code is {run value, run length 1..127}; longer runs are split.
//
// Ports:
//   clk, RST            - clock, asynchronous active-high reset
//   start               - one-cycle job request (honoured only when idle)
//   baseAddr, byteCount - region start address and length, sampled with start
//   ramAddress          - RAM read address
//   read_signal         - RAM read strobe
//   ramDataOut          - RAM read data, valid on the edge after read_signal
//   code_out            - RLE code
//   code_valid          - code_out holds a code
//   code_ready          - consumer accepts the code
//   busy                - job in progress
//   done                - one-cycle end-of-job pulse
//   codeCount           - codes emitted in the current/last job
module compress_handler #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              start,
  input  logic [ADDR_W-1:0] baseAddr,
  input  logic [LEN_W-1:0]  byteCount,
  output logic [ADDR_W-1:0] ramAddress,
  output logic              read_signal,
  input  logic [7:0]        ramDataOut,
  output logic [7:0]        code_out,
  output logic              code_valid,
  input  logic              code_ready,
  output logic              busy,
  output logic              done,
  output logic [LEN_W+3:0]  codeCount
);

  typedef enum logic [2:0] {
    IDLE, READ, CAPTURE, SCAN, EMIT, FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  off_q, off_d;
  logic [7:0]        shreg_q, shreg_d;
  logic [3:0]        bitcnt_q, bitcnt_d;
  logic              run_val_q, run_val_d;
  logic [6:0]        run_len_q, run_len_d;
  logic              final_q, final_d;
  logic [LEN_W+3:0]  code_count_q, code_count_d;

  logic              cur_bit;
  logic [LEN_W-1:0]  off_inc;

  assign cur_bit   = shreg_q[7];
  assign off_inc   = off_q + 1'b1;
  assign codeCount = code_count_q;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      base_q       <= '0;
      len_q        <= '0;
      off_q        <= '0;
      shreg_q      <= '0;
      bitcnt_q     <= '0;
      run_val_q    <= 1'b0;
      run_len_q    <= '0;
      final_q      <= 1'b0;
      code_count_q <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      len_q        <= len_d;
      off_q        <= off_d;
      shreg_q      <= shreg_d;
      bitcnt_q     <= bitcnt_d;
      run_val_q    <= run_val_d;
      run_len_q    <= run_len_d;
      final_q      <= final_d;
      code_count_q <= code_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    len_d        = len_q;
    off_d        = off_q;
    shreg_d      = shreg_q;
    bitcnt_d     = bitcnt_q;
    run_val_d    = run_val_q;
    run_len_d    = run_len_q;
    final_d      = final_q;
    code_count_d = code_count_q;
    ramAddress   = '0;
    read_signal  = 1'b0;
    code_out     = '0;
    code_valid   = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          base_d       = baseAddr;
          len_d        = byteCount;
          off_d        = '0;
          code_count_d = '0;
          run_len_d    = '0;
          final_d      = 1'b0;
          state_d      = (byteCount == '0) ? FINISH : READ;
        end
      end
      READ: begin
        busy        = 1'b1;
        read_signal = 1'b1;
        ramAddress  = base_q + ADDR_W'(off_q);
        state_d     = CAPTURE;
      end
      CAPTURE: begin
        busy     = 1'b1;
        shreg_d  = ramDataOut;
        bitcnt_d = 4'd8;
        state_d  = SCAN;
      end
      SCAN: begin
        busy = 1'b1;
        // A fresh run always takes the bit; otherwise the bit only joins a
        // matching run with room left, else the run is flushed first and the
        // same bit is re-examined on return from EMIT.
        if (run_len_q == '0 || (cur_bit == run_val_q && run_len_q != 7'd127)) begin
          run_val_d = cur_bit;
          run_len_d = run_len_q + 7'd1;
          shreg_d   = {shreg_q[6:0], 1'b0};
          bitcnt_d  = bitcnt_q - 4'd1;
          if (bitcnt_q == 4'd1) begin
            off_d = off_inc;
            if (off_inc == len_q) begin
              final_d = 1'b1;
              state_d = EMIT;
            end else begin
              state_d = READ;
            end
          end
        end else begin
          state_d = EMIT;
        end
      end
      EMIT: begin
        busy       = 1'b1;
        code_valid = 1'b1;
        code_out   = {run_val_q, run_len_q};
        if (code_ready) begin
          code_count_d = code_count_q + 1'b1;
          run_len_d    = '0;
          state_d      = final_q ? FINISH : SCAN;
        end
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_compress_handler.sv
module tb_compress_handler;

  localparam int ADDR_W = 16;
  localparam int LEN_W  = 16;

  logic              clk = 1'b0;
  logic              RST;
  logic              start;
  logic [ADDR_W-1:0] baseAddr;
  logic [LEN_W-1:0]  byteCount;
  logic [ADDR_W-1:0] ramAddress;
  logic              read_signal;
  logic [7:0]        ramDataOut;
  logic [7:0]        code_out;
  logic              code_valid;
  logic              code_ready;
  logic              busy;
  logic              done;
  logic [LEN_W+3:0]  codeCount;

  compress_handler #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .RST        (RST),
    .start      (start),
    .baseAddr   (baseAddr),
    .byteCount  (byteCount),
    .ramAddress (ramAddress),
    .read_signal(read_signal),
    .ramDataOut (ramDataOut),
    .code_out   (code_out),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .busy       (busy),
    .done       (done),
    .codeCount  (codeCount)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:65535];
  always @(posedge clk) if (read_signal) ramDataOut <= mem[ramAddress];

  int checks = 0;
  int errors = 0;
  logic [7:0]        exp_q[$];
  logic [ADDR_W-1:0] rd_addr_q[$];
  int                rd_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted code is popped and compared.
  always @(negedge clk) begin
    if (RST !== 1'b1) begin
      if (read_signal) begin
        rd_cnt++;
        rd_addr_q.push_back(ramAddress);
      end
      if (code_valid && code_ready) begin
        if (exp_q.size() == 0) chk("unexpected_code", {24'd0, code_out}, 32'hFFFF_FFFF);
        else chk("code", {24'd0, code_out}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic issue_start(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] n);
    rd_cnt = 0;
    rd_addr_q.delete();
    @(posedge clk); #1;
    baseAddr  = b;
    byteCount = n;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
  endtask

  task automatic finish_job(input string nm, input int n_codes, input int n_reads);
    chk({nm, "_codes_left"}, exp_q.size(), 0);
    chk({nm, "_codeCount"}, codeCount, n_codes);
    chk({nm, "_reads"}, rd_cnt, n_reads);
  endtask

  task automatic check_read_latency();
    @(negedge clk);
    chk("read_latency", {31'd0, read_signal}, 32'd1);
  endtask

  initial begin
    logic [7:0] held;
    bit found;
    for (int unsigned i = 0; i < 65536; i++) mem[i] = 8'h00;
    RST = 1'b1; start = 1'b0; baseAddr = '0; byteCount = '0; code_ready = 1'b1;
    #1;
    chk("rst_read_signal", {31'd0, read_signal}, 0);
    chk("rst_code_valid", {31'd0, code_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_codeCount", codeCount, 0);
    chk("rst_ramAddress", ramAddress, 0);
    chk("rst_code_out", code_out, 0);
    repeat (2) @(posedge clk);
    #1 RST = 1'b0;

    // Single byte of ones.
    mem[16'h0100] = 8'hFF;
    exp_q.push_back(8'h88);
    issue_start(16'h0100, 1);
    check_read_latency();
    wait_done(200);
    finish_job("ff", 1, 1);

    // Two runs in one byte.
    mem[16'h0110] = 8'hF0;
    exp_q.push_back(8'h84); exp_q.push_back(8'h04);
    issue_start(16'h0110, 1);
    check_read_latency();
    wait_done(200);
    finish_job("f0", 2, 1);

    // Run continues across a byte boundary.
    mem[16'h0300] = 8'h0F; mem[16'h0301] = 8'hFF;
    exp_q.push_back(8'h04); exp_q.push_back(8'h8C);
    issue_start(16'h0300, 2);
    check_read_latency();
    wait_done(300);
    finish_job("span", 2, 2);

    // Empty job.
    issue_start(16'h0500, 0);
    wait_done(2);
    finish_job("zero", 0, 0);

    // 136 zeros split as 127 + 9; address wraps past 0xFFFF.
    exp_q.push_back(8'h7F); exp_q.push_back(8'h09);
    issue_start(16'hFFFF, 17);
    check_read_latency();
    wait_done(2000);
    finish_job("long", 2, 17);
    if (rd_addr_q.size() >= 2) begin
      chk("wrap_addr0", rd_addr_q[0], 32'h0000_FFFF);
      chk("wrap_addr1", rd_addr_q[1], 32'h0000_0000);
    end else chk("wrap_reads", rd_addr_q.size(), 17);

    // Consumer stall: code held stable with no reads for 5+ cycles.
    mem[16'h0200] = 8'hF0;
    exp_q.push_back(8'h84); exp_q.push_back(8'h04);
    code_ready = 1'b0;
    issue_start(16'h0200, 1);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (code_valid) begin found = 1'b1; break; end
    end
    chk("stall_valid_seen", {31'd0, found}, 1);
    held = code_out;
    chk("stall_code", held, 8'h84);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, code_valid}, 1);
      chk("stall_stable", code_out, held);
      chk("stall_no_read", {31'd0, read_signal}, 0);
    end
    @(posedge clk); #1 code_ready = 1'b1;
    wait_done(200);
    finish_job("stall", 2, 1);

    // Reset during SCAN after one code has been accepted.
    mem[16'h0400] = 8'hAA; mem[16'h0401] = 8'hAA;
    exp_q.push_back(8'h81);
    issue_start(16'h0400, 2);
    repeat (6) @(posedge clk);
    #2;
    chk("pre_rst_busy", {31'd0, busy}, 1);
    chk("pre_rst_codeCount", codeCount, 1);
    RST = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_codeCount", codeCount, 0);
    chk("mid_rst_code_valid", {31'd0, code_valid}, 0);
    chk("mid_rst_code_out", code_out, 0);
    chk("mid_rst_read", {31'd0, read_signal}, 0);
    chk("mid_rst_ramAddress", ramAddress, 0);
    chk("mid_rst_codes_left", exp_q.size(), 0);
    @(posedge clk); #1 RST = 1'b0;

    // Alternating bits after reset.
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'h81); exp_q.push_back(8'h01);
    end
    issue_start(16'h0400, 1);
    check_read_latency();
    wait_done(300);
    finish_job("aa", 8, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/compress_handler.md
COMPRESS_HANDLER -- requirements
Module: compress_handler

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, RAM byte-address width.
REQ-002 The block SHALL have parameter LEN_W, default 16, byte-count width.
REQ-003 The block SHALL have port clk, input, 1, single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port RST, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, one-cycle request to compress a region.
REQ-006 The block SHALL have port baseAddr, input, ADDR_W, first byte address, sampled with start.
REQ-007 The block SHALL have port byteCount, input, LEN_W, number of bytes to compress, sampled with start.
REQ-008 The block SHALL have port ramAddress, output, ADDR_W, RAM read address.
REQ-009 The block SHALL have port read_signal, output, 1, RAM read strobe.
REQ-010 The block SHALL have port ramDataOut, input, 8, RAM read data, valid on the edge after read_signal.
REQ-011 The block SHALL have port code_out, output, 8, RLE code: bit7 = run value, bits6:0 = run length 1..127.
REQ-012 The block SHALL have port code_valid, output, 1, code_out holds a code.
REQ-013 The block SHALL have port code_ready, input, 1, consumer accepts code.
REQ-014 The block SHALL have port busy, output, 1, high from the cycle after accepted start until done.
REQ-015 The block SHALL have port done, output, 1, one-cycle pulse at end of job.
REQ-016 The block SHALL have port codeCount, output, LEN_W+4, codes emitted in the current/last job.

Function
REQ-017 Bit order SHALL be ascending byte address, bit 7 first within each byte; the code format SHALL be the exact inverse of decompress_handler's in1 format.
REQ-018 The FSM SHALL have states IDLE, READ, CAPTURE, SCAN, EMIT, FINISH.
REQ-019 IDLE: on start=1, the block SHALL latch baseAddr/byteCount, clear codeCount and run_len, and go to FINISH if byteCount=0, else READ; start SHALL be ignored outside IDLE.
REQ-020 READ: read_signal=1 for exactly one cycle with ramAddress = base + byte offset, modulo 2^ADDR_W; next state CAPTURE.
REQ-021 CAPTURE: ramDataOut SHALL be latched into an 8-bit shift register with bit counter = 8; next state SCAN.
REQ-022 SCAN SHALL examine one bit per cycle:
- run_len=0: load run_val=bit, run_len=1, consume bit.
- bit=run_val and run_len<127: increment run_len, consume bit.
- otherwise: go to EMIT without consuming the bit.
REQ-023 After the last bit of a byte is consumed, SCAN SHALL go to READ if bytes remain, else to EMIT (final flush); runs SHALL continue across byte boundaries.
REQ-024 EMIT: code_valid=1 with code_out={run_val, run_len[6:0]}, held stable until code_ready=1.
REQ-025 On the code_valid&code_ready edge, the block SHALL increment codeCount, clear run_len, and return to SCAN, or to FINISH if this was the final flush.
REQ-026 With code_ready tied high, EMIT SHALL last exactly one cycle.
REQ-027 FINISH: done=1 for one cycle, busy=0; next state IDLE.
REQ-028 A run longer than 127 SHALL be split into 127-length codes followed by the remainder; no zero-length code SHALL ever be emitted.
REQ-029 No RAM read SHALL be issued while in EMIT.
REQ-030 Latency from start: read_signal SHALL be high in cycle +1, first bit scanned in cycle +3.

Reset
REQ-031 RST=1 SHALL force IDLE immediately and drive ramAddress=0, read_signal=0, code_out=0, code_valid=0, busy=0, done=0, codeCount=0, regardless of clk.
REQ-032 Reset mid-job SHALL discard any pending code; the first start after reset release SHALL run normally.

Verification
REQ-033 byteCount=1, mem[base]=0xFF, code_ready=1 -> single code 0x88, done pulse, codeCount=1.
REQ-034 byteCount=1, mem=0xF0 -> codes 0x84 then 0x04, codeCount=2.
REQ-035 byteCount=0 -> done pulse 2 cycles after start, no read_signal, no code_valid.
REQ-036 byteCount=17, all 0x00 -> codes 0x7F then 0x09; base=0xFFFF with ADDR_W=16 -> reads wrap to address 0x0000.
REQ-037 code_ready held low 5 cycles during EMIT -> code_out and code_valid stable, read_signal=0, and the code is accepted once when ready rises.
REQ-038 RST pulsed during SCAN -> all outputs zero asynchronously; next job with mem=0xAA -> eight codes alternating 0x81 and 0x01.
